ram: RTL and testbench

// - Single-port synchronous 16 x 8 random-access memory with a registered read port.
// - Used as a small scratch/lookup store: one clock domain, one address bus shared by

---
 rtl/ram.sv | 40 ++++
 tb/tb_ram.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-port 16x8 synchronous RAM with a registered read port and write-through
// on simultaneous read/write. Async active-low reset clears contents and dout.
module ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [ADDR_WIDTH-1:0] add,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] w_rdata;

   // A same-edge write wins over the stored word so dout never shows stale data.
   assign w_rdata = wr ? din : r_mem[add];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (wr) begin
         r_mem[add] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    r_dout <= '0;
      else if (rd) r_dout <= w_rdata;
   end

   assign dout = r_dout;

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: a reference model pushes the expected dout for each
// driven cycle; the value is popped and compared just after the clock edge.
module tb_ram;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr  = 1'b0;
   logic          rd  = 1'b0;
   logic [AW-1:0] add = '0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;

   ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .add(add), .din(din), .dout(dout)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] m_mem [16];
   logic [DW-1:0] m_dout;
   logic [DW-1:0] sb_q [$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: dout=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         chk(tag, dout, sb_q.pop_front());
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_dout = '0;
   endtask

   // One clock cycle of stimulus; model updated with the same edge semantics.
   task automatic cyc(input logic w, input logic r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string tag);
      @(negedge clk);
      wr = w; rd = r; add = a; din = d;
      if (w && r)  m_dout = d;
      else if (r)  m_dout = m_mem[a];
      if (w)       m_mem[a] = d;
      sb_q.push_back(m_dout);
      @(posedge clk);
      #1;
      pop_chk(tag);
   endtask

   initial begin
      model_reset();
      #1;
      sb_q.push_back(m_dout);
      pop_chk("reset_async");

      // Strobes during reset must be ignored.
      wr = 1'b1; rd = 1'b1; add = 4'h9; din = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      sb_q.push_back(m_dout);
      pop_chk("reset_hold");
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 16; i++)
         cyc(1'b0, 1'b1, AW'(i), 8'h00, $sformatf("rd_clear_%0d", i));

      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, AW'(i), DW'(i), $sformatf("wr_%0d", i));
         cyc(1'b0, 1'b1, AW'(i), 8'h00, $sformatf("rd_back_%0d", i));
      end

      cyc(1'b1, 1'b1, 4'h3, 8'hC3, "wr_through");
      cyc(1'b0, 1'b0, 4'h0, 8'h00, "idle_after_wt");
      cyc(1'b0, 1'b1, 4'h3, 8'h00, "rd_after_wt");

      cyc(1'b0, 1'b1, 4'h5, 8'h00, "rd_5");
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, AW'(i), 8'hEE, $sformatf("idle_hold_%0d", i));
      cyc(1'b1, 1'b0, 4'h6, 8'hFF, "wr_no_dout");
      cyc(1'b0, 1'b1, 4'h6, 8'h00, "rd_6");

      for (int i = 0; i < 16; i++)
         cyc(1'b1, 1'b0, AW'(i), DW'($urandom_range(1, 255)), $sformatf("fill_%0d", i));
      cyc(1'b0, 1'b1, 4'h7, 8'h00, "rd_7_filled");

      // Reset pulse entirely between clock edges.
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      #1 rst = 1'b0;
      #1;
      model_reset();
      sb_q.push_back(m_dout);
      pop_chk("reset_mid");
      #1 rst = 1'b1;

      cyc(1'b0, 1'b1, 4'h0, 8'h00, "post_rst_0");
      cyc(1'b0, 1'b1, 4'h7, 8'h00, "post_rst_7");
      cyc(1'b0, 1'b1, 4'hF, 8'h00, "post_rst_15");

      cyc(1'b1, 1'b0, 4'h0, 8'h11, "wr_0");
      cyc(1'b1, 1'b0, 4'hF, 8'hAA, "wr_15_aa");
      cyc(1'b1, 1'b0, 4'hF, 8'h55, "wr_15_55");
      cyc(1'b0, 1'b1, 4'hF, 8'h00, "rd_15_over");
      cyc(1'b0, 1'b1, 4'h0, 8'h00, "rd_0_intact");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
